// File: rtl/usb_fs_host_tx.sv
// USB full-speed host transmitter: serialises bytes with SYNC, NRZI coding,
// bit stuffing and EOP onto the D+/D- drivers, one bit per CLKS_PER_BIT clocks.
module usb_fs_host_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk48_host,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       usb_d_p_o,
   output logic       usb_d_n_o,
   output logic       usb_tx_en,
   output logic       busy,
   output logic       underflow
);

   localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [7:0]      SYNC_PAT = 8'h80;

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

   state_t           state;
   logic [CNT_W-1:0] phase;
   logic [2:0]       bit_idx;
   logic [2:0]       ones;
   logic [7:0]       shift;
   logic             last_q;
   logic             line_j;

   logic bit_end;
   logic stuff_now;
   logic byte_done;
   logic fetch;
   logic launch;
   logic launch_bit;
   logic nxt_j;

   function automatic logic nrzi(input logic cur_j, input logic b);
      return b ? cur_j : ~cur_j;
   endfunction

   assign bit_end   = (phase == PH_LAST);
   assign stuff_now = (ones == 3'd6);
   // bit_idx is the next bit to send; it wraps to 0 once bit 7 has gone out
   assign byte_done = (bit_idx == 3'd0);
   assign fetch     = ((state == IDLE) && tx_valid) ||
                      ((state == DATA) && bit_end && !stuff_now && byte_done && !last_q && tx_valid);
   assign nxt_j     = nrzi(line_j, launch_bit);

   always_comb begin
      launch     = 1'b0;
      launch_bit = 1'b0;
      case (state)
         IDLE: begin
            if (tx_valid) begin
               launch     = 1'b1;
               launch_bit = SYNC_PAT[0];
            end
         end
         SYNC: begin
            if (bit_end) begin
               launch     = 1'b1;
               launch_bit = byte_done ? shift[0] : SYNC_PAT[bit_idx];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (stuff_now) begin
                  launch     = 1'b1;
                  launch_bit = 1'b0;
               end else if (!byte_done) begin
                  launch     = 1'b1;
                  launch_bit = shift[bit_idx];
               end else if (fetch) begin
                  launch     = 1'b1;
                  launch_bit = tx_data[0];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk48_host) begin
      if (fetch) shift <= tx_data;
   end

   always_ff @(posedge clk48_host or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         phase     <= '0;
         bit_idx   <= '0;
         ones      <= '0;
         last_q    <= 1'b0;
         line_j    <= 1'b1;
         usb_tx_en <= 1'b0;
         usb_d_p_o <= 1'b1;
         usb_d_n_o <= 1'b0;
         tx_ready  <= 1'b0;
         busy      <= 1'b0;
         underflow <= 1'b0;
      end else begin
         tx_ready  <= 1'b0;
         underflow <= 1'b0;

         if (launch) begin
            line_j    <= nxt_j;
            usb_d_p_o <= nxt_j;
            usb_d_n_o <= ~nxt_j;
            ones      <= launch_bit ? ones + 3'd1 : 3'd0;
         end

         if (state == IDLE) phase <= '0;
         else               phase <= bit_end ? '0 : phase + 1'b1;

         case (state)
            IDLE: begin
               if (tx_valid) begin
                  state     <= SYNC;
                  tx_ready  <= 1'b1;
                  usb_tx_en <= 1'b1;
                  busy      <= 1'b1;
                  bit_idx   <= 3'd1;
                  last_q    <= tx_last;
               end
            end
            SYNC: begin
               if (bit_end) begin
                  bit_idx <= bit_idx + 3'd1;
                  if (byte_done) state <= DATA;
               end
            end
            DATA: begin
               // a pending stuffed bit always goes out before the byte fetch or EOP
               if (bit_end && !stuff_now) begin
                  if (!byte_done) begin
                     bit_idx <= bit_idx + 3'd1;
                  end else if (fetch) begin
                     tx_ready <= 1'b1;
                     last_q   <= tx_last;
                     bit_idx  <= 3'd1;
                  end else begin
                     state     <= EOP_SE0;
                     underflow <= !last_q;
                     usb_d_p_o <= 1'b0;
                     usb_d_n_o <= 1'b0;
                  end
               end
            end
            EOP_SE0: begin
               if (bit_end) begin
                  if (bit_idx == 3'd1) begin
                     state     <= EOP_J;
                     bit_idx   <= 3'd0;
                     usb_d_p_o <= 1'b1;
                     usb_d_n_o <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            EOP_J: begin
               if (bit_end) begin
                  state     <= IDLE;
                  usb_tx_en <= 1'b0;
                  busy      <= 1'b0;
                  line_j    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_fs_host_tx.sv
// Randomised bench for usb_fs_host_tx: a bit-level line model predicts every
// cycle of each packet, plus directed SYNC/stuffing/underflow/reset cases.
module tb_usb_fs_host_tx;

   localparam int CPB = 4;

   logic       clk48_host = 1'b0;
   logic       reset      = 1'b1;
   logic [7:0] tx_data    = 8'h00;
   logic       tx_valid   = 1'b0;
   logic       tx_last    = 1'b0;
   logic       tx_ready, usb_d_p_o, usb_d_n_o, usb_tx_en, busy, underflow;

   int n_chk  = 0;
   int n_fail = 0;

   logic [1:0] exp_sym[$];
   int         exp_rdy[$];
   int         exp_uf[$];
   logic [1:0] rec_sym[$];
   bit         rec_rdy[$];
   bit         rec_uf[$];
   bit         rec_busy[$];
   logic [1:0] idle_sym;
   logic       idle_busy;

   always #5 clk48_host = ~clk48_host;

   usb_fs_host_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk48_host(clk48_host),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_last   (tx_last),
      .tx_ready  (tx_ready),
      .usb_d_p_o (usb_d_p_o),
      .usb_d_n_o (usb_d_n_o),
      .usb_tx_en (usb_tx_en),
      .busy      (busy),
      .underflow (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Line symbols are {D+,D-}: J=10, K=01, SE0=00.
   task automatic build_model(input logic [7:0] b[$], input int nsent, input bit uf);
      int         raw[$];
      int         bits[$];
      int         run = 0;
      logic [1:0] lvl = 2'b10;
      logic [7:0] sync_pat = 8'h80;
      exp_sym.delete();
      exp_rdy.delete();
      exp_uf.delete();
      exp_rdy.push_back(0);
      for (int i = 0; i < 8; i++) raw.push_back(int'(sync_pat[i]));
      for (int k = 0; k < nsent; k++)
         for (int i = 0; i < 8; i++) raw.push_back(int'(b[k][i]));
      for (int r = 0; r < raw.size(); r++) begin
         if (r >= 16 && (r % 8) == 0) exp_rdy.push_back(bits.size() * CPB);
         bits.push_back(raw[r]);
         run = (raw[r] != 0) ? run + 1 : 0;
         if (run == 6) begin
            bits.push_back(0);
            run = 0;
         end
      end
      if (uf) exp_uf.push_back(bits.size() * CPB);
      foreach (bits[i]) begin
         if (bits[i] == 0) lvl = (lvl == 2'b10) ? 2'b01 : 2'b10;
         exp_sym.push_back(lvl);
      end
      exp_sym.push_back(2'b00);
      exp_sym.push_back(2'b00);
      exp_sym.push_back(2'b10);
   endtask

   task automatic drive_packet(input logic [7:0] b[$], input bit uf, input bit hold);
      int n = uf ? 1 : b.size();
      for (int k = 0; k < n; k++) begin
         int w = 0;
         @(negedge clk48_host);
         tx_data  = b[k];
         tx_valid = 1'b1;
         tx_last  = !uf && (k == n - 1);
         do begin
            @(negedge clk48_host);
            w++;
         end while (!tx_ready && w < 400);
         if (!tx_ready) chk("ready_timeout", 0, 1);
      end
      if (!hold) begin
         tx_valid = 1'b0;
         tx_last  = 1'b0;
      end
   endtask

   task automatic record_packet(output int gap);
      int n = 0;
      gap = 0;
      rec_sym.delete();
      rec_rdy.delete();
      rec_uf.delete();
      rec_busy.delete();
      @(negedge clk48_host);
      while (!usb_tx_en && gap < 600) begin
         gap++;
         @(negedge clk48_host);
      end
      if (!usb_tx_en) begin
         chk("start_timeout", 0, 1);
         return;
      end
      while (usb_tx_en && n < 1000) begin
         rec_sym.push_back({usb_d_p_o, usb_d_n_o});
         rec_rdy.push_back(tx_ready);
         rec_uf.push_back(underflow);
         rec_busy.push_back(busy);
         n++;
         @(negedge clk48_host);
      end
      idle_sym  = {usb_d_p_o, usb_d_n_o};
      idle_busy = busy;
   endtask

   task automatic compare_packet(input string tag);
      int rd[$];
      int uf[$];
      int both = 0;
      int bcnt = 0;
      int lim;
      chk($sformatf("%s:en_cycles", tag), rec_sym.size(), exp_sym.size() * CPB);
      lim = (rec_sym.size() < exp_sym.size() * CPB) ? rec_sym.size() : exp_sym.size() * CPB;
      for (int i = 0; i < lim; i++)
         chk($sformatf("%s:line[%0d]", tag, i), rec_sym[i], exp_sym[i / CPB]);
      foreach (rec_rdy[i]) begin
         if (rec_rdy[i]) rd.push_back(i);
         if (rec_uf[i]) uf.push_back(i);
         if (rec_rdy[i] && rec_uf[i]) both++;
         if (rec_busy[i]) bcnt++;
      end
      chk($sformatf("%s:ready_pulses", tag), rd.size(), exp_rdy.size());
      for (int j = 0; j < rd.size() && j < exp_rdy.size(); j++)
         chk($sformatf("%s:ready_cycle[%0d]", tag, j), rd[j], exp_rdy[j]);
      chk($sformatf("%s:uf_pulses", tag), uf.size(), exp_uf.size());
      for (int j = 0; j < uf.size() && j < exp_uf.size(); j++)
         chk($sformatf("%s:uf_cycle", tag), uf[j], exp_uf[j]);
      chk($sformatf("%s:ready_and_uf", tag), both, 0);
      chk($sformatf("%s:busy_cycles", tag), bcnt, rec_sym.size());
      chk($sformatf("%s:idle_line", tag), idle_sym, 2'b10);
      chk($sformatf("%s:idle_busy", tag), idle_busy, 0);
   endtask

   task automatic run_packet(input logic [7:0] b[$], input bit uf, input string tag);
      int g;
      build_model(b, uf ? 1 : b.size(), uf);
      fork
         drive_packet(b, uf, 1'b0);
         record_packet(g);
      join
      compare_packet(tag);
   endtask

   initial begin
      logic [7:0] p[$];
      logic [7:0] q[$];
      int         g;

      // reset state
      repeat (3) @(posedge clk48_host);
      @(negedge clk48_host);
      chk("rst:en", usb_tx_en, 0);
      chk("rst:line", {usb_d_p_o, usb_d_n_o}, 2'b10);
      chk("rst:busy", busy, 0);
      chk("rst:ready", tx_ready, 0);
      chk("rst:uf", underflow, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk48_host);

      p.delete(); p.push_back(8'h00);
      run_packet(p, 1'b0, "byte00");
      p.delete(); p.push_back(8'hFF);
      run_packet(p, 1'b0, "byteFF");
      p.delete(); p.push_back(8'h2D); p.push_back(8'h00); p.push_back(8'h10);
      run_packet(p, 1'b0, "three");
      p.delete(); p.push_back(8'hA5); p.push_back(8'h3C);
      run_packet(p, 1'b1, "underflow");
      p.delete(); p.push_back(8'hFF); p.push_back(8'hFF); p.push_back(8'hFC);
      run_packet(p, 1'b0, "stuff_chain");

      // reset in the middle of DATA
      @(negedge clk48_host);
      tx_data  = 8'h55;
      tx_last  = 1'b1;
      tx_valid = 1'b1;
      @(negedge clk48_host);
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      repeat (48) @(negedge clk48_host);
      chk("midrst:en_before", usb_tx_en, 1);
      #2 reset = 1'b1;
      #1;
      chk("midrst:en", usb_tx_en, 0);
      chk("midrst:line", {usb_d_p_o, usb_d_n_o}, 2'b10);
      chk("midrst:busy", busy, 0);
      chk("midrst:ready", tx_ready, 0);
      chk("midrst:uf", underflow, 0);
      @(negedge clk48_host);
      reset = 1'b0;
      p.delete(); p.push_back(8'($urandom));
      run_packet(p, 1'b0, "after_rst");

      for (int t = 0; t < 6; t++) begin
         int len = $urandom_range(1, 4);
         bit uf;
         p.delete();
         for (int k = 0; k < len; k++)
            p.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
         uf = (len > 1) && ($urandom_range(0, 3) == 0);
         run_packet(p, uf, $sformatf("rand%0d", t));
      end

      // back-to-back packets with tx_valid held high through EOP
      p.delete(); p.push_back(8'($urandom)); p.push_back(8'hFF);
      q.delete(); q.push_back(8'($urandom));
      fork
         begin
            drive_packet(p, 1'b0, 1'b1);
            drive_packet(q, 1'b0, 1'b0);
         end
         begin
            build_model(p, p.size(), 1'b0);
            record_packet(g);
            compare_packet("b2b_first");
            build_model(q, q.size(), 1'b0);
            record_packet(g);
            chk("b2b:gap", g, 0);
            compare_packet("b2b_second");
         end
      join

      repeat (4) @(negedge clk48_host);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/usb_fs_host_tx.md
USB_FS_HOST_TX -- requirements
Module: usb_fs_host_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 4, meaning clk48_host cycles per USB full-speed bit time (48 MHz / 12 Mbps).
REQ-002 SHALL provide port clk48_host  input  1  meaning single clock; all logic is clocked on its rising edge.
REQ-003 SHALL provide port reset  input  1  meaning asynchronous, active-high reset.
REQ-004 SHALL provide port tx_data  input  8  meaning packet byte, transmitted LSB first.
REQ-005 SHALL provide port tx_valid  input  1  meaning tx_data holds a valid byte.
REQ-006 SHALL provide port tx_last  input  1  meaning the current byte is the final byte of the packet; qualified by tx_valid.
REQ-007 SHALL provide port tx_ready  output  1  meaning one-cycle pulse when the presented byte is consumed.
REQ-008 SHALL provide port usb_d_p_o  output  1  meaning D+ drive value.
REQ-009 SHALL provide port usb_d_n_o  output  1  meaning D- drive value.
REQ-010 SHALL provide port usb_tx_en  output  1  meaning output enable for both data pins.
REQ-011 SHALL provide port busy  output  1  meaning high from packet start until the end of EOP.
REQ-012 SHALL provide port underflow  output  1  meaning one-cycle pulse on packet truncation.

Function
REQ-013 SHALL implement states IDLE, SYNC, DATA, EOP_SE0 and EOP_J.
REQ-014 Line encoding SHALL be: J = (d_p=1, d_n=0); K = (0,1); SE0 = (0,0).
REQ-015 In IDLE, outputs SHALL be usb_tx_en=0, J, busy=0, and the NRZI line state SHALL be J.
REQ-016 IDLE with tx_valid=1 SHALL move to SYNC, pulse tx_ready, load tx_data/tx_last into the shift register, and drive usb_tx_en=1 with the first SYNC bit on the next clock.
REQ-017 Each bit, including stuffed bits, SHALL be held exactly CLKS_PER_BIT cycles, using a bit-phase counter that resets at packet start.
REQ-018 SYNC SHALL send the pattern 0x80 LSB first (seven 0s, then one 1) through the NRZI path, giving K J K J K J K K.
REQ-019 NRZI: a 0 bit SHALL toggle the line J<->K; a 1 bit SHALL hold the line.
REQ-020 Bit stuffing:
- a ones counter SHALL clear at SYNC start and on any 0, and increment on each 1;
- SYNC's final 1 SHALL count;
- after the sixth consecutive 1, one stuffed 0 SHALL be inserted and the counter SHALL clear;
- stuffing SHALL carry across byte boundaries and SHALL apply after the last data bit.
REQ-021 Byte fetch at the bit boundary after bit 7 of a non-last byte:
- if tx_valid=1: pulse tx_ready, load the byte, continue DATA with no gap;
- if tx_valid=0: pulse underflow, go to EOP_SE0.
REQ-022 After bit 7 of a last byte, plus any pending stuffed bit, the block SHALL go to EOP_SE0 without asserting tx_ready.
REQ-023 EOP_SE0 SHALL drive SE0 for 2 bit times; EOP_J SHALL then drive J with usb_tx_en=1 for 1 bit time; the block SHALL then return to IDLE with usb_tx_en=0 and busy=0.
REQ-024 tx_ready SHALL never pulse outside SYNC-entry or DATA byte boundaries.
REQ-025 tx_valid changes during EOP SHALL be ignored; a new packet SHALL start no earlier than the first IDLE cycle.
REQ-026 tx_ready and underflow SHALL never be high in the same cycle.

Reset
REQ-027 While reset=1, independent of the clock, the block SHALL force: state IDLE, usb_tx_en=0, usb_d_p_o=1, usb_d_n_o=0, tx_ready=0, busy=0, underflow=0, and all counters cleared.
REQ-028 Reset asserted mid-packet SHALL abort the packet with no EOP; the first packet after reset release SHALL start from line state J.

Verification
REQ-029 Bench SHALL check single byte 0x00 with tx_last=1 -> line K J K J K J K K | J K J K J K J K | SE0 SE0 J, usb_tx_en high exactly 76 cycles, one tx_ready pulse.
REQ-030 Bench SHALL check single byte 0xFF with tx_last=1 -> after SYNC: K K K K K, stuffed J, J J J, then SE0 SE0 J; usb_tx_en high 80 cycles.
REQ-031 Bench SHALL check bytes 0x2D, 0x00, 0x10 (last) with tx_valid held high -> 3 tx_ready pulses, each one bit boundary after the previous byte's bit 7, no idle bits between bytes, busy low only after EOP_J.
REQ-032 Bench SHALL check underflow: 2-byte packet with tx_valid dropped before byte 2 -> underflow pulse, SE0 starts at the next bit boundary, no second tx_ready.
REQ-033 Bench SHALL check reset asserted during DATA -> usb_tx_en=0, J on D+/D- in the same cycle; the next packet begins SYNC with K.
REQ-034 Bench SHALL run back-to-back packets with tx_valid held high through EOP -> the second SYNC begins exactly one cycle after the first IDLE cycle.
